acc: RTL and testbench

- Registered 128-bit binary adder with carry-in, the accumulate/add stage of the arithmetic datapath.
- Each enabled clock it captures data_in1 + data_in2 + data_cin into a 129-bit output register; the extra bit is the carry-out.
- Output holds when not enabled and clears on reset.

---
 rtl/acc.sv | 104 ++++++++++
 tb/tb_acc.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/acc.sv
// Registered WIDTH-bit adder with carry-in; the sum register's top bit holds the carry-out.
// The adder core is a two-level carry-lookahead (GROUP-bit blocks, GROUP-block supergroups).
module acc #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned GROUP = 4    // must divide WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             data_cin,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    output logic [WIDTH:0]   data_out
);

    localparam int unsigned NB = WIDTH / GROUP;          // lookahead blocks
    localparam int unsigned NS = (NB + GROUP - 1) / GROUP; // supergroups of blocks

    logic [WIDTH-1:0] g, p, c;
    logic [NB-1:0]    bg, bp, bc;
    logic [NS-1:0]    sg, sp, sc;
    logic             cout;
    logic [WIDTH:0]   sum;
    logic             gg, pp, carry;

    always_comb begin
        g     = data_in1 & data_in2;
        p     = data_in1 ^ data_in2;
        bg    = '0;
        bp    = '0;
        bc    = '0;
        sg    = '0;
        sp    = '0;
        sc    = '0;
        c     = '0;
        gg    = 1'b0;
        pp    = 1'b1;
        carry = 1'b0;
        cout  = 1'b0;

        // Block generate/propagate from bit-level g/p.
        for (int unsigned k = 0; k < NB; k++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int unsigned j = 0; j < GROUP; j++) begin
                gg = g[k*GROUP+j] | (p[k*GROUP+j] & gg);
                pp = pp & p[k*GROUP+j];
            end
            bg[k] = gg;
            bp[k] = pp;
        end

        // Supergroup generate/propagate from block g/p.
        for (int unsigned s = 0; s < NS; s++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int unsigned j = 0; j < GROUP; j++) begin
                if (s*GROUP + j < NB) begin
                    gg = bg[s*GROUP+j] | (bp[s*GROUP+j] & gg);
                    pp = pp & bp[s*GROUP+j];
                end
            end
            sg[s] = gg;
            sp[s] = pp;
        end

        carry = data_cin;
        for (int unsigned s = 0; s < NS; s++) begin
            sc[s] = carry;
            carry = sg[s] | (sp[s] & carry);
        end
        cout = carry;

        // Distribute supergroup carries to blocks, then block carries to bits.
        for (int unsigned s = 0; s < NS; s++) begin
            carry = sc[s];
            for (int unsigned j = 0; j < GROUP; j++) begin
                if (s*GROUP + j < NB) begin
                    bc[s*GROUP+j] = carry;
                    carry = bg[s*GROUP+j] | (bp[s*GROUP+j] & carry);
                end
            end
        end

        for (int unsigned k = 0; k < NB; k++) begin
            carry = bc[k];
            for (int unsigned j = 0; j < GROUP; j++) begin
                c[k*GROUP+j] = carry;
                carry = g[k*GROUP+j] | (p[k*GROUP+j] & carry);
            end
        end

        sum = {cout, p ^ c};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
        end else if (enable) begin
            data_out <= sum;
        end
    end

endmodule

// File: tb/tb_acc.sv
// Self-checking bench for acc: directed literal checks plus randomized traffic compared every
// cycle against an arithmetic reference model.
module tb_acc;

    localparam int unsigned WIDTH = 128;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             data_cin;
    logic [WIDTH-1:0] data_in1;
    logic [WIDTH-1:0] data_in2;
    logic [WIDTH:0]   data_out;

    logic [WIDTH:0]   exp_out;
    int               n_checks;
    int               n_fails;

    acc #(.WIDTH(WIDTH), .GROUP(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .data_cin (data_cin),
        .data_in1 (data_in1),
        .data_in2 (data_in2),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain wide arithmetic, cleared asynchronously by reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) exp_out <= '0;
        else if (enable) exp_out <= {1'b0, data_in1} + {1'b0, data_in2} + {{WIDTH{1'b0}}, data_cin};
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        n_checks++;
        if (data_out !== exp_out) begin
            n_fails++;
            $display("FAIL model_cmp t=%0t got=%h want=%h", $time, data_out, exp_out);
        end
    end

    task automatic check_lit(input string name, input logic [WIDTH:0] want);
        n_checks++;
        if (data_out !== want) begin
            n_fails++;
            $display("FAIL %s got=%h want=%h", name, data_out, want);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_op();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '1;
            1:       v = '0;
            2:       v = {4{32'hAAAA_AAAA}};
            3:       v = {4{32'h5555_5555}};
            default: v = {$urandom, $urandom, $urandom, $urandom};
        endcase
        return v;
    endfunction

    // Drive one operand set after a falling edge, then sample #1 after the next rising edge.
    task automatic step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input logic en, input string name, input logic [WIDTH:0] want);
        @(negedge clk);
        data_in1 = a;
        data_in2 = b;
        data_cin = cin;
        enable   = en;
        @(posedge clk);
        #1;
        check_lit(name, want);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        enable   = 1'b1;
        data_cin = 1'b1;
        data_in1 = rnd_op();
        data_in2 = rnd_op();
        #1 reset = 1'b0;

        // Reset held across two edges with live inputs and enable.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_lit("reset_hold", '0);
            data_in1 = rnd_op();
            data_in2 = rnd_op();
        end
        @(negedge clk);
        reset = 1'b1;
        step(128'hF, 128'hF, 1'b1, 1'b1, "first_load", 129'h1F);

        step(128'hAAAA_AAAA, 128'h5555_5555, 1'b1, 1'b1, "prop32", 129'h1_0000_0000);
        step(128'hAAAA, 128'h5555, 1'b1, 1'b1, "prop16", 129'h1_0000);
        step(128'hFFFF, 128'hFFFF, 1'b0, 1'b1, "no_cin", 129'h1_FFFE);
        step('1, '1, 1'b1, 1'b1, "max_sum", {(WIDTH+1){1'b1}});
        step('1, '0, 1'b1, 1'b1, "carry_out_only", {1'b1, {WIDTH{1'b0}}});

        // Enable hold with changing inputs.
        step(128'hF, 128'hF, 1'b1, 1'b1, "hold_load", 129'h1F);
        for (int i = 0; i < 3; i++) begin
            step(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'b0, "hold", 129'h1F);
        end
        step(128'h3, 128'h4, 1'b0, 1'b1, "reenable", 129'h7);

        // Asynchronous reset between edges, no clock needed.
        step(128'hFFFF, 128'hFFFF, 1'b0, 1'b1, "pre_async", 129'h1_FFFE);
        #2 reset = 1'b0;
        #1;
        check_lit("async_reset", '0);
        @(negedge clk);
        reset = 1'b1;
        step(128'h1, 128'h1, 1'b1, 1'b1, "post_async", 129'h3);

        // Randomized traffic, including occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            data_in1 = rnd_op();
            data_in2 = rnd_op();
            data_cin = 1'($urandom_range(0, 1));
            enable   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) begin
                #2 reset = 1'b0;
                @(posedge clk);
                #1 reset = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
